// File: rtl/lab3_seq_detector_param.sv
// Parametrised serial pattern detector with KMP fall-back, selectable
// Mealy/Moore flag, overlap control, enable and saturating match counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE (0)   | no pattern prefix matches the tail of accepted input
// 1..PAT_LEN-2 | longest matching pattern prefix has this many bits
// S_LAST       | PAT_LEN-1 bits matched; the next correct bit completes a match
// >= PAT_LEN   | unused encoding, returns to S_IDLE on the next clock
module lab3_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = 1'b0,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clr_count,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic [SW-1:0]    state_dbg
);

    typedef enum logic [SW-1:0] {
        S_IDLE = '0,
        S_LAST = SW'(PAT_LEN - 1)
    } state_t;

    localparam int PAT_I = int'(PATTERN);

    // Bit number idx (0 = first received) of "first s pattern bits followed by b".
    function automatic int seq_bit(int s, int b, int idx);
        int r;
        if (idx == s) r = b;
        else          r = (PAT_I >> (PAT_LEN - 1 - idx)) & 1;
        return r;
    endfunction

    // Next prefix length after accepting b in state s: advance on a correct
    // bit, otherwise the longest proper border of (prefix + b). Evaluated
    // only at elaboration to build the transition tables.
    function automatic int next_fn(int s, int b);
        int res;
        bit ok;
        res = 0;
        if (s < PAT_LEN) begin
            if ((s < PAT_LEN - 1) && (b == ((PAT_I >> (PAT_LEN - 1 - s)) & 1))) begin
                res = s + 1;
            end else begin
                for (int k = 1; k <= s; k++) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (seq_bit(s, b, s + 1 - k + j) != ((PAT_I >> (PAT_LEN - 1 - j)) & 1))
                            ok = 1'b0;
                    end
                    if (ok) res = k;
                end
            end
        end
        return res;
    endfunction

    // Restart point after a full match when overlapping is allowed.
    localparam int          F_FULL = next_fn(PAT_LEN - 1, PAT_I & 1);
    localparam logic [SW-1:0] F_ST = SW'(F_FULL);

    logic [SW-1:0] fb0 [2**SW];
    logic [SW-1:0] fb1 [2**SW];

    // Transition tables for x=0 / x=1; unused encodings map to 0.
    for (genvar i = 0; i < 2**SW; i++) begin : g_fb
        localparam int N0 = next_fn(i, 0);
        localparam int N1 = next_fn(i, 1);
        assign fb0[i] = SW'(N0);
        assign fb1[i] = SW'(N1);
    end

    state_t s_q;
    state_t s_d;
    logic   match;

    assign match     = en & (s_q == S_LAST) & (x == PATTERN[0]);
    assign state_dbg = s_q;

    // Prefix-length state register.
    always_ff @(posedge clock) begin
        if (reset) s_q <= S_IDLE;
        else       s_q <= s_d;
    end

    // Next-state selection: hold when disabled, restart or fall back otherwise.
    always_comb begin
        s_d = s_q;
        if (int'(s_q) > PAT_LEN - 1) begin
            s_d = S_IDLE;
        end else if (match) begin
            s_d = OVERLAP ? state_t'(F_ST) : S_IDLE;
        end else if (en) begin
            s_d = x ? state_t'(fb1[s_q]) : state_t'(fb0[s_q]);
        end
    end

    if (MOORE) begin : g_moore
        logic z_q;
        // Registered flag, one cycle after the completing bit; holds while en=0.
        always_ff @(posedge clock) begin
            if (reset)   z_q <= 1'b0;
            else if (en) z_q <= match;
        end
        assign z = z_q;
    end else begin : g_mealy
        assign z = match & ~reset;
    end

    // Saturating match counter; a clear beats a simultaneous match.
    always_ff @(posedge clock) begin
        if (reset)                            match_count <= '0;
        else if (clr_count)                   match_count <= '0;
        else if (match && (match_count != '1)) match_count <= match_count + 1'b1;
    end

endmodule

// File: tb/tb_lab3_seq_detector_param.sv
// Bench for lab3_seq_detector_param: six parameterisations share one input
// stream and are compared every cycle against a history-based reference.
module tb_lab3_seq_detector_param;

    localparam int NI = 6;

    logic clock = 1'b0;
    logic reset, en, x, clr_count;

    logic       z0, z1, z2, z3, z4, z5;
    logic [7:0] c0, c1, c2, c5;
    logic [1:0] c3;
    logic [3:0] c4;
    logic [1:0] s0, s1, s2, s3, s5;
    logic [2:0] s4;

    always #5 clock = ~clock;

    lab3_seq_detector_param d0 (.clock(clock), .reset(reset), .en(en), .x(x), .clr_count(clr_count),
                                .z(z0), .match_count(c0), .state_dbg(s0));
    lab3_seq_detector_param #(.OVERLAP(1'b0)) d1 (.clock(clock), .reset(reset), .en(en), .x(x),
                                .clr_count(clr_count), .z(z1), .match_count(c1), .state_dbg(s1));
    lab3_seq_detector_param #(.MOORE(1'b1)) d2 (.clock(clock), .reset(reset), .en(en), .x(x),
                                .clr_count(clr_count), .z(z2), .match_count(c2), .state_dbg(s2));
    lab3_seq_detector_param #(.CNT_W(2)) d3 (.clock(clock), .reset(reset), .en(en), .x(x),
                                .clr_count(clr_count), .z(z3), .match_count(c3), .state_dbg(s3));
    lab3_seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b10010), .MOORE(1'b1), .CNT_W(4)) d4 (
                                .clock(clock), .reset(reset), .en(en), .x(x), .clr_count(clr_count),
                                .z(z4), .match_count(c4), .state_dbg(s4));
    lab3_seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111)) d5 (.clock(clock), .reset(reset),
                                .en(en), .x(x), .clr_count(clr_count), .z(z5), .match_count(c5),
                                .state_dbg(s5));

    int p_len [NI] = '{4, 4, 4, 4, 5, 3};
    int p_pat [NI] = '{11, 11, 11, 11, 18, 7};
    int p_ov  [NI] = '{1, 0, 1, 1, 1, 1};
    int p_mo  [NI] = '{0, 0, 1, 0, 1, 0};
    int p_cw  [NI] = '{8, 8, 8, 2, 4, 8};

    // Reference: accepted-bit history (newest in bit 0), Moore flag, count.
    longint unsigned hist [NI];
    int hlen [NI];
    int zq   [NI];
    int cnt  [NI];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Does accepting xin complete the pattern in the last plen accepted bits?
    function automatic int m_match(int i, int xin);
        longint unsigned h, mask;
        h    = (hist[i] << 1) | longint'(xin);
        mask = (longint'(1) << p_len[i]) - 1;
        return ((hlen[i] + 1 >= p_len[i]) && ((h & mask) == longint'(p_pat[i]))) ? 1 : 0;
    endfunction

    // Longest pattern prefix shorter than the pattern ending the history.
    function automatic int m_state(int i);
        int res;
        res = 0;
        for (int k = 1; k < p_len[i]; k++) begin
            if ((hlen[i] >= k) &&
                ((hist[i] & ((longint'(1) << k) - 1)) == longint'(p_pat[i] >> (p_len[i] - k))))
                res = k;
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            hist[i] = 0; hlen[i] = 0; zq[i] = 0; cnt[i] = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit xb, input bit c);
        int gz [NI];
        int gc [NI];
        int gs [NI];
        int mt [NI];
        int ez;
        reset = r; en = e; x = xb; clr_count = c;
        @(negedge clock);
        gz = '{int'(z0), int'(z1), int'(z2), int'(z3), int'(z4), int'(z5)};
        gc = '{int'(c0), int'(c1), int'(c2), int'(c3), int'(c4), int'(c5)};
        gs = '{int'(s0), int'(s1), int'(s2), int'(s3), int'(s4), int'(s5)};
        for (int i = 0; i < NI; i++) begin
            mt[i] = (e && !r) ? m_match(i, int'(xb)) : 0;
            ez    = p_mo[i] ? zq[i] : mt[i];
            check($sformatf("z[%0d]@%0d", i, cyc), gz[i], ez);
            check($sformatf("count[%0d]@%0d", i, cyc), gc[i], cnt[i]);
            check($sformatf("state[%0d]@%0d", i, cyc), gs[i], m_state(i));
        end
        @(posedge clock);
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                hist[i] = 0; hlen[i] = 0; zq[i] = 0; cnt[i] = 0;
            end else begin
                if (c) cnt[i] = 0;
                else if (mt[i] != 0 && cnt[i] != (1 << p_cw[i]) - 1) cnt[i]++;
                if (e) begin
                    zq[i]   = mt[i];
                    hist[i] = (hist[i] << 1) | longint'(xb);
                    hlen[i] = (hlen[i] < 60) ? hlen[i] + 1 : 60;
                    if (mt[i] != 0 && p_ov[i] == 0) begin
                        hist[i] = 0; hlen[i] = 0;
                    end
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run_bits(input string bits, input bit e);
        for (int k = 0; k < bits.len(); k++) step(1'b0, e, bits[k] == "1", 1'b0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; x = 1'b0; clr_count = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Overlapping stream with two matches for the default pattern.
        run_bits("1011011", 1'b1);
        check("t1_count", int'(c0), 2);
        check("t2_count", int'(c1), 1);
        check("t6_count_partial", int'(c3), 2);

        // Enable dropped between every bit.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, (k != 1), 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t4_count", int'(c0), 1);

        // Reset mid-pattern discards the partial prefix.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_bits("101", 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run_bits("1", 1'b1);
        check("t5_state", int'(s0), 1);
        check("t5_count", int'(c0), 0);

        // Five overlapping matches saturate the 2-bit counter, then clear wins.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_bits("1011011011011011", 1'b1);
        check("t6_count_sat", int'(c3), 3);
        check("t6_count_full", int'(c0), 5);
        run_bits("01", 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("t6_clr_with_match", int'(c3), 0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
